// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1, LSB first) fed by the baud tick generator.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects odd parity).
module uart_rx #(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int NB_TICKCNT = 5,
  parameter int NB_BITCNT  = $clog2(NB_DATA)
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic               o_parity_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  localparam logic [NB_TICKCNT-1:0] TICK_HALF = NB_TICKCNT'(7);
  localparam logic [NB_TICKCNT-1:0] TICK_LAST = NB_TICKCNT'(15);
  localparam logic [NB_TICKCNT-1:0] TICK_STOP = NB_TICKCNT'(SB_TICK - 1);
  localparam logic [NB_BITCNT-1:0]  BIT_LAST  = NB_BITCNT'(NB_DATA - 1);

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic [NB_TICKCNT-1:0] tick_q, tick_d;
  logic [NB_BITCNT-1:0]  bit_q, bit_d;
  logic [NB_DATA-1:0]    shift_q, shift_d;
  logic [NB_DATA-1:0]    data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit_q, par_bit_d;
  logic                  perr_q, perr_d;
`endif
  logic                  rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!i_reset) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], i_rx};
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_q == TICK_HALF) begin
            // Line back high at mid start bit: a glitch, not a frame.
            if (!rx_s) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[NB_DATA-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            par_bit_d = rx_s;
            tick_d    = '0;
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (i_tick) begin
          if (tick_q == TICK_STOP) begin
            data_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_bit_q ^ PARITY_ODD;
`endif
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data       = data_q;
  assign o_rx_done    = done_q;
  assign o_frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, scored against a frame-level model.
// Define UART_RX_PARITY_EN on both files to exercise the parity build.
module tb_uart_rx;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick  = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int tick_num = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         tick;
  } frame_t;

  frame_t     got_q[$];
  frame_t     exp_q[$];
  frame_t     mon_f;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

  uart_rx dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  always #5 i_clock = ~i_clock;

  // One tick every 4 clocks, random starting phase.
  initial begin : tick_gen
    int div;
    div = int'($urandom_range(0, 3));
    forever begin
      @(negedge i_clock);
      i_tick = (div == 3);
      if (div == 3) tick_num++;
      div = (div + 1) % 4;
    end
  end

  // Records every cycle in which done is high; a stretched pulse shows up as extra records.
  initial begin : monitor
    forever begin
      @(negedge i_clock);
      if (o_rx_done === 1'b1) begin
        mon_f.data = o_data;
        mon_f.ferr = o_frame_err;
`ifdef UART_RX_PARITY_EN
        mon_f.perr = o_parity_err;
`else
        mon_f.perr = 1'b0;
`endif
        mon_f.tick = tick_num;
        got_q.push_back(mon_f);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_ticks(input int n);
    repeat (n * 4) @(negedge i_clock);
  endtask

  // Drives one frame and records what a correct receiver must report for it.
  // A low stop bit is cut to 12 ticks so the line is high again before a re-armed start check.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    i_rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      hold_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par;
    hold_ticks(16);
`endif
    i_rx = stop;
    hold_ticks(stop ? 16 : 12);
    i_rx = 1'b1;
    exp_q.push_back('{data: d, ferr: ~stop, perr: (^d) ^ par, tick: 0});
    last_data = d;
    last_ferr = ~stop;
    last_perr = (^d) ^ par;
  endtask

  task automatic verify(input string tag);
    frame_t g, e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, {24'h0, g.data}, {24'h0, e.data});
      check({tag, "_ferr"}, {31'h0, g.ferr}, {31'h0, e.ferr});
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, {31'h0, g.perr}, {31'h0, e.perr});
`endif
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_held_data"}, {24'h0, o_data}, {24'h0, last_data});
    check({tag, "_held_ferr"}, {31'h0, o_frame_err}, {31'h0, last_ferr});
  endtask

  initial begin : stimulus
    int         gap;
    logic [7:0] rd;
    logic       rs;
    logic [7:0] rst_byte;

    // Reset state
    i_reset = 1'b0;
    repeat (3) @(negedge i_clock);
    check("reset_data", {24'h0, o_data}, 32'h0);
    check("reset_done", {31'h0, o_rx_done}, 32'h0);
    check("reset_ferr", {31'h0, o_frame_err}, 32'h0);
`ifdef UART_RX_PARITY_EN
    check("reset_perr", {31'h0, o_parity_err}, 32'h0);
`endif
    i_reset = 1'b1;
    hold_ticks(20);

    // Single good frame, then 20 quiet bit times
    send_frame(8'hA5, 1'b1, 1'b0);
    hold_ticks(20 * 16);
    verify("a5");

    // Start glitch of 3 ticks must be rejected
    i_rx = 1'b0;
    hold_ticks(3);
    i_rx = 1'b1;
    hold_ticks(40);
    verify("glitch");

    // Framing error, then recovery with a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_ticks(20);
    verify("frame_err");
    send_frame(8'h55, 1'b1, 1'b0);
    hold_ticks(20);
    verify("recover");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold_ticks(20);
    gap = (got_q.size() >= 2) ? (got_q[1].tick - got_q[0].tick) : -1;
    check("b2b_gap_160", {31'h0, (gap >= 159 && gap <= 161)}, 32'h1);
    verify("b2b");

    // Reset during bit 4 of 0x81: frame discarded, outputs cleared
    rst_byte = 8'h81;
    i_rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 4; i++) begin
      i_rx = rst_byte[i];
      hold_ticks(16);
    end
    i_rx = rst_byte[4];
    hold_ticks(8);
    i_reset = 1'b0;
    i_rx    = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    last_data = 8'h00;
    last_ferr = 1'b0;
    last_perr = 1'b0;
    check("midrst_data", {24'h0, o_data}, 32'h0);
    check("midrst_ferr", {31'h0, o_frame_err}, 32'h0);
    hold_ticks(30);
    verify("midrst");
    send_frame(8'h7E, 1'b1, 1'b0);
    hold_ticks(20);
    verify("after_rst");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has odd weight, so parity bit 1 is correct and 0 is an error
    send_frame(8'h07, 1'b1, 1'b1);
    hold_ticks(20);
    verify("par_ok");
    check("par_ok_held", {31'h0, o_parity_err}, {31'h0, last_perr});
    send_frame(8'h07, 1'b1, 1'b0);
    hold_ticks(20);
    verify("par_bad");
    check("par_bad_held", {31'h0, o_parity_err}, {31'h0, last_perr});
`endif

    // Random frames with random stop bits and idle gaps
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, 1'($urandom));
      gap = rs ? int'($urandom_range(0, 24)) : int'($urandom_range(8, 24));
      hold_ticks(gap);
    end
    hold_ticks(20);
    verify("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that sits directly downstream of the baud tick generator.
- Consumes the 16x-oversampling tick and the serial line, and recovers 8N1 frames (LSB first).
- Presents each received byte with a one-cycle done strobe and a framing-error flag to the RX FIFO / interface logic.
- Sampling is mid-bit, counted in ticks; no clock-rate assumptions beyond the tick rate.

Parameters:
NB_DATA, 8, data bits per frame
SB_TICK, 16, ticks spent in stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
NB_TICKCNT, 5, width of tick counter; must satisfy 2^NB_TICKCNT > SB_TICK-1
NB_BITCNT, $clog2(NB_DATA), width of data-bit counter

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous reset, active-low (0 = reset)
i_tick  in  1  one-cycle strobe at 16x baud from tick generator
i_rx  in  1  asynchronous serial line, idle high
o_data  out  NB_DATA  last received byte, held until next completed frame
o_rx_done  out  1  one-cycle pulse on frame completion
o_frame_err  out  1  stop-bit sample of last frame was 0; valid with o_rx_done, held until next completion

Behaviour:
- Reset: i_reset==0 sampled on a rising edge of i_clock forces:
  - state=IDLE; tick/bit counters=0; shift reg=0.
  - o_data=0, o_rx_done=0, o_frame_err=0.
  - Synchronizer flops=1.
  - Applies mid-frame: the partial frame is discarded, no done pulse.
- Input sync: i_rx passes through 2 flops (reset to 1); rx_s is the second flop. All decisions use rx_s.
- IDLE: rx_s==0 (on any clock, tick not required) -> START, tick_cnt=0.
- START: on i_tick:
  - tick_cnt==7: rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0; rx_s==1 -> IDLE (false start, no outputs change).
  - else tick_cnt++.
- DATA: on i_tick:
  - tick_cnt==15: shift_reg={rx_s, shift_reg[NB_DATA-1:1]}, tick_cnt=0. If bit_cnt==NB_DATA-1 -> STOP, else bit_cnt++.
  - else tick_cnt++.
- STOP: on i_tick:
  - tick_cnt==SB_TICK-1: register o_data=shift_reg, o_frame_err=~rx_s, o_rx_done=1 for exactly one clock, -> IDLE.
  - else tick_cnt++.
- Cycles without i_tick: counters hold in START/DATA/STOP.
- o_rx_done is registered and is 0 in every cycle other than the completion cycle. It pulses even on framing error.
- Break (line held low): each frame completes with o_data=0x00, o_frame_err=1. The FSM then re-enters START immediately from IDLE. No lockup.
- Next start edge may be accepted the cycle after returning to IDLE (back-to-back frames supported).
- Latency: o_rx_done rises 1 clock after the tick that ends the stop bit.
- The sync adds 2 clocks between the line edge and START entry.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP: 16 ticks, sampled at tick_cnt==15.
  - Adds parameter PARITY_ODD (default 0 = even).
  - Adds port o_parity_err (out, 1). Set at completion to (XOR of data bits ^ parity bit ^ PARITY_ODD) != 0. Reset 0, held like o_frame_err.
- Undefined: no PARITY state, no o_parity_err port; frame is strictly 8N1 per above.

Test Plan:
- Setup: tick every 4 clocks. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> exactly one o_rx_done pulse, o_data=0xA5, o_frame_err=0. No other done pulses over 20 bit times.
- Glitch: drive i_rx low for 3 ticks, then high -> FSM returns to IDLE, o_rx_done never asserts, o_data unchanged.
- Framing: send 0x3C with stop bit 0, then line high -> o_rx_done pulse, o_data=0x3C, o_frame_err=1. Next good frame 0x55 -> o_frame_err=0.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two done pulses, 160 ticks apart ±1 tick, data 0x00 then 0xFF.
- Reset mid-frame: assert i_reset=0 during bit 4 of 0x81 for 2 clocks, release, then send 0x7E -> no pulse for 0x81; o_data=0 after reset, then 0x7E, err=0.
- Parity (UART_RX_PARITY_EN, even): send 0x07 with parity 1 -> o_parity_err=0; same with parity 0 -> o_parity_err=1.
